// File: rtl/isolde_decoder_pkg.sv
// Shared types for the ISOLDE decoder/issue path.
// Contents:
//   isolde_opcode_e      - decoded ISOLDE custom opcode
//   isolde_issue_entry_t - one buffered instruction {opcode, func3, funct2}
//   IssueEntryReset      - value held by empty/reset queue slots
//   issue_state_e        - occupancy state of the issue queue
//   DefaultIssueDepth    - default number of issue queue entries
package isolde_decoder_pkg;

    localparam int unsigned DefaultIssueDepth = 4;

    typedef enum logic [3:0] {
        isolde_opcode_nop     = 4'd0,
        isolde_opcode_gemm    = 4'd1,
        isolde_opcode_conv2d  = 4'd2,
        isolde_opcode_redmule = 4'd3,
        isolde_opcode_mac     = 4'd4,
        isolde_opcode_vload   = 4'd5,
        isolde_opcode_vstore  = 4'd6
    } isolde_opcode_e;

    typedef struct packed {
        isolde_opcode_e opcode;
        logic [2:0]     func3;
        logic [1:0]     funct2;
    } isolde_issue_entry_t;

    localparam isolde_issue_entry_t IssueEntryReset = '{
        opcode: isolde_opcode_nop,
        func3:  3'b000,
        funct2: 2'b00
    };

    typedef enum logic [1:0] {
        ISSUE_EMPTY  = 2'd0,
        ISSUE_ACTIVE = 2'd1,
        ISSUE_FULL   = 2'd2
    } issue_state_e;

endpackage

// File: rtl/isolde_issue_fifo_mem.sv
// Storage for the issue queue: Depth x isolde_issue_entry_t register array.
// Ports:
//   clk_i     - clock
//   clr_i     - synchronous clear of every slot to IssueEntryReset
//   wr_en_i   - write wr_data_i into slot wr_ptr_i at the next edge
//   wr_ptr_i  - write slot index
//   wr_data_i - entry to store
//   rd_ptr_i  - read slot index
//   rd_data_o - combinational (async) read of slot rd_ptr_i
// Slots are cleared so the head fields are never X, even when the queue is
// empty; this is why the array is registers rather than block RAM.
module isolde_issue_fifo_mem
    import isolde_decoder_pkg::*;
#(
    parameter int unsigned Depth    = DefaultIssueDepth,
    parameter int unsigned PtrWidth = $clog2(Depth)
) (
    input  logic                clk_i,
    input  logic                clr_i,
    input  logic                wr_en_i,
    input  logic [PtrWidth-1:0] wr_ptr_i,
    input  isolde_issue_entry_t wr_data_i,
    input  logic [PtrWidth-1:0] rd_ptr_i,
    output isolde_issue_entry_t rd_data_o
);

    isolde_issue_entry_t mem_reg [Depth];

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem_reg[i] <= IssueEntryReset;
            end
        end else if (wr_en_i) begin
            mem_reg[wr_ptr_i] <= wr_data_i;
        end
    end

    // Depth is a power of two, so every pointer value is a valid index.
    assign rd_data_o = mem_reg[rd_ptr_i];

endmodule

// File: rtl/isolde_issue_queue.sv
// Issue queue between the ISOLDE decoder and the ISOLDE exec block.
// Buffers decoded instructions and presents the oldest one to the exec block,
// honouring its stall back-pressure.
// Ports:
//   clk_i, rst_i            - clock, synchronous active-high reset
//   flush_i                 - drop all queued entries (priority over enq/deq)
//   dec_valid_i, dec_*_i    - instruction offered by the decoder
//   dec_ready_o             - queue not full (registered-state based)
//   issue_ready_o, issue_*  - head entry valid and its fields
//   exec_stall_i            - exec block cannot take the head this cycle
//   count_o                 - current occupancy
// Optional (macro ISOLDE_ISSUE_STATS_EN):
//   stat_issued_o, stat_stall_o, stat_full_o - saturating 32-bit event
//   counters, cleared only by rst_i.
module isolde_issue_queue
    import isolde_decoder_pkg::*;
#(
    parameter int unsigned Depth    = DefaultIssueDepth,
    parameter int unsigned CntWidth = $clog2(Depth) + 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    input  logic                dec_valid_i,
    input  isolde_opcode_e      dec_opcode_i,
    input  logic [2:0]          dec_func3_i,
    input  logic [1:0]          dec_funct2_i,
    output logic                dec_ready_o,
    output logic                issue_ready_o,
    output isolde_opcode_e      issue_opcode_o,
    output logic [2:0]          issue_func3_o,
    output logic [1:0]          issue_funct2_o,
    input  logic                exec_stall_i,
    output logic [CntWidth-1:0] count_o
`ifdef ISOLDE_ISSUE_STATS_EN
    ,
    output logic [31:0]         stat_issued_o,
    output logic [31:0]         stat_stall_o,
    output logic [31:0]         stat_full_o
`endif
);

    localparam int unsigned PtrWidth = $clog2(Depth);
    localparam logic [CntWidth-1:0] CountFull = CntWidth'(Depth);

    issue_state_e        state_reg, state_next;
    logic [CntWidth-1:0] count_reg, count_next;
    logic [PtrWidth-1:0] wr_ptr_reg, rd_ptr_reg;
    logic                enq, deq;
    isolde_issue_entry_t wr_entry, head_entry;

    // Both handshakes depend only on registered state: a full queue refuses
    // a push even when the head leaves in the same cycle.
    assign dec_ready_o   = (state_reg != ISSUE_FULL);
    assign issue_ready_o = (state_reg != ISSUE_EMPTY);
    assign enq           = dec_valid_i && dec_ready_o;
    assign deq           = issue_ready_o && !exec_stall_i;

    always_comb begin
        count_next = count_reg;
        case ({enq, deq})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_comb begin
        state_next = ISSUE_ACTIVE;
        if (count_next == '0) begin
            state_next = ISSUE_EMPTY;
        end else if (count_next == CountFull) begin
            state_next = ISSUE_FULL;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            state_reg  <= ISSUE_EMPTY;
            count_reg  <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            // Pointers are exactly PtrWidth bits, so increment wraps mod Depth.
            if (enq) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (deq) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    assign wr_entry = '{opcode: dec_opcode_i, func3: dec_func3_i, funct2: dec_funct2_i};

    isolde_issue_fifo_mem #(
        .Depth    (Depth),
        .PtrWidth (PtrWidth)
    ) u_mem (
        .clk_i     (clk_i),
        .clr_i     (rst_i || flush_i),
        .wr_en_i   (enq),
        .wr_ptr_i  (wr_ptr_reg),
        .wr_data_i (wr_entry),
        .rd_ptr_i  (rd_ptr_reg),
        .rd_data_o (head_entry)
    );

    assign issue_opcode_o = head_entry.opcode;
    assign issue_func3_o  = head_entry.func3;
    assign issue_funct2_o = head_entry.funct2;
    assign count_o        = count_reg;

`ifdef ISOLDE_ISSUE_STATS_EN
    logic [31:0] stat_issued_reg, stat_stall_reg, stat_full_reg;

    // Flush does not clear the counters; a dequeue squashed by a flush is
    // not an issue.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stat_issued_reg <= '0;
            stat_stall_reg  <= '0;
            stat_full_reg   <= '0;
        end else begin
            if (deq && !flush_i && stat_issued_reg != '1) begin
                stat_issued_reg <= stat_issued_reg + 1'b1;
            end
            if (issue_ready_o && exec_stall_i && stat_stall_reg != '1) begin
                stat_stall_reg <= stat_stall_reg + 1'b1;
            end
            if (dec_valid_i && !dec_ready_o && stat_full_reg != '1) begin
                stat_full_reg <= stat_full_reg + 1'b1;
            end
        end
    end

    assign stat_issued_o = stat_issued_reg;
    assign stat_stall_o  = stat_stall_reg;
    assign stat_full_o   = stat_full_reg;
`endif

endmodule
